// File: rtl/zest_spi_arb_if.sv
// Bus bundle for the shared-SPI arbiter: per-device requester signals plus
// the shared SCLK/SDIO pad side. The arbiter takes the slave modport.
interface zest_spi_arb_if #(
    parameter int N_DEV = 4,
    parameter int DW    = 24,
    parameter int LW    = 5
);
    logic [N_DEV-1:0]    req;
    logic [N_DEV*DW-1:0] wr_data;
    logic [N_DEV*LW-1:0] nbits;
    logic [N_DEV-1:0]    rd;
    logic [N_DEV-1:0]    gnt;
    logic [N_DEV-1:0]    done;
    logic [DW-1:0]       rdata;
    logic                busy;
    logic                sclk;
    logic [N_DEV-1:0]    csb;
    logic                sdo;
    logic                sdio_oe;
    logic                sdi;

    modport slave (
        input  req, wr_data, nbits, rd, sdi,
        output gnt, done, rdata, busy, sclk, csb, sdo, sdio_oe
    );

    modport master (
        output req, wr_data, nbits, rd, sdi,
        input  gnt, done, rdata, busy, sclk, csb, sdo, sdio_oe
    );
endinterface

// File: rtl/zest_spi_arb.sv
// Round-robin arbiter and SPI master shared by several devices on one
// SCLK/SDIO pair. Mode 0 clocking, per-device CSB, optional 3-wire read
// turnaround after ADDR_BITS, and an enforced all-CSB-high gap between
// transactions.
module zest_spi_arb #(
    parameter int N_DEV     = 4,
    parameter int DW        = 24,
    parameter int LW        = 5,
    parameter int CLK_DIV   = 4,
    parameter int ADDR_BITS = 16,
    parameter int CS_GAP    = 2
) (
    input  logic           clk,
    input  logic           rst,
    zest_spi_arb_if.slave  bus
);

    localparam int PW   = (N_DEV > 1)   ? $clog2(N_DEV)   : 1;
    localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW   = (CS_GAP > 1)  ? $clog2(CS_GAP)  : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t            state_q;
    logic [PW-1:0]     rrPtr_q;
    logic [N_DEV-1:0]  gnt_q;
    logic [N_DEV-1:0]  done_q;
    logic [N_DEV-1:0]  csb_q;
    logic [DW-1:0]     rdata_q;
    logic [DW-1:0]     txShift_q;
    logic [DW-1:0]     rxShift_q;
    logic [LW-1:0]     nbits_q;
    logic [LW-1:0]     bitCnt_q;
    logic [DIVW-1:0]   div_q;
    logic [GW-1:0]     gap_q;
    logic              rdEff_q;
    logic              busy_q;
    logic              sclk_q;
    logic              sdo_q;
    logic              sdioOe_q;

    logic              grantHit_d;
    logic [PW-1:0]     grantIdx_d;
    logic [PW-1:0]     rrPtr_d;
    logic [N_DEV-1:0]  oneHot_d;
    logic [DW-1:0]     selData_d;
    logic [LW-1:0]     selNbits_d;
    logic [LW-1:0]     nbitsClamp_d;
    logic              rdEff_d;

    // Pick the first requester at or after the round-robin pointer and stage its transaction fields.
    always_comb begin : arbSearch
        int cand;
        grantHit_d = 1'b0;
        grantIdx_d = '0;
        cand       = 0;
        for (int k = 0; k < N_DEV; k++) begin
            cand = (int'(rrPtr_q) + k) % N_DEV;
            if (!grantHit_d && bus.req[cand]) begin
                grantHit_d = 1'b1;
                grantIdx_d = PW'(cand);
            end
        end
        oneHot_d             = '0;
        oneHot_d[grantIdx_d] = grantHit_d;
        rrPtr_d      = (grantIdx_d == PW'(N_DEV - 1)) ? '0 : grantIdx_d + 1'b1;
        selData_d    = bus.wr_data[grantIdx_d*DW +: DW];
        selNbits_d   = bus.nbits[grantIdx_d*LW +: LW];
        nbitsClamp_d = (selNbits_d > LW'(DW)) ? LW'(DW) : selNbits_d;
        rdEff_d      = bus.rd[grantIdx_d] && (nbitsClamp_d > LW'(ADDR_BITS));
    end

    // Transaction sequencer: grant, bit shifting, CSB hold, inter-transaction gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rrPtr_q   <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            csb_q     <= '1;
            rdata_q   <= '0;
            txShift_q <= '0;
            rxShift_q <= '0;
            nbits_q   <= '0;
            bitCnt_q  <= '0;
            div_q     <= '0;
            gap_q     <= '0;
            rdEff_q   <= 1'b0;
            busy_q    <= 1'b0;
            sclk_q    <= 1'b0;
            sdo_q     <= 1'b0;
            sdioOe_q  <= 1'b0;
        end else begin
            done_q <= '0;
            case (state_q)
                IDLE: begin
                    if (grantHit_d) begin
                        rrPtr_q   <= rrPtr_d;
                        gnt_q     <= oneHot_d;
                        busy_q    <= 1'b1;
                        txShift_q <= selData_d;
                        rxShift_q <= '0;
                        nbits_q   <= nbitsClamp_d;
                        rdEff_q   <= rdEff_d;
                        bitCnt_q  <= '0;
                        div_q     <= '0;
                        sclk_q    <= 1'b0;
                        if (nbitsClamp_d != '0) begin
                            csb_q    <= ~oneHot_d;
                            sdioOe_q <= 1'b1;
                            sdo_q    <= selData_d[DW-1];
                            state_q  <= SHIFT;
                        end else begin
                            state_q  <= HOLD;
                        end
                    end
                end
                SHIFT: begin
                    if (div_q == DIVW'(CLK_DIV - 1)) begin
                        div_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                            if (rdEff_q && (bitCnt_q >= LW'(ADDR_BITS))) begin
                                rxShift_q <= {rxShift_q[DW-2:0], bus.sdi};
                            end
                        end else begin
                            sclk_q <= 1'b0;
                            if (bitCnt_q == nbits_q - 1'b1) begin
                                state_q <= HOLD;
                            end else begin
                                bitCnt_q  <= bitCnt_q + 1'b1;
                                txShift_q <= {txShift_q[DW-2:0], 1'b0};
                                sdo_q     <= txShift_q[DW-2];
                                if (rdEff_q && (bitCnt_q == LW'(ADDR_BITS - 1))) begin
                                    sdioOe_q <= 1'b0;
                                end
                            end
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                HOLD: begin
                    if ((nbits_q == '0) || (div_q == DIVW'(CLK_DIV - 1))) begin
                        div_q    <= '0;
                        csb_q    <= '1;
                        sdioOe_q <= 1'b0;
                        sdo_q    <= 1'b0;
                        done_q   <= gnt_q;
                        gnt_q    <= '0;
                        gap_q    <= '0;
                        if (rdEff_q) begin
                            rdata_q <= rxShift_q;
                        end
                        state_q  <= GAP;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_q == GW'(CS_GAP - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.rdata   = rdata_q;
    assign bus.busy    = busy_q;
    assign bus.sclk    = sclk_q;
    assign bus.csb     = csb_q;
    assign bus.sdo     = sdo_q;
    assign bus.sdio_oe = sdioOe_q;

endmodule

// File: tb/tb_zest_spi_arb.sv
// Scoreboard bench for zest_spi_arb: the stimulus side predicts grant order
// and per-transaction results and queues them; a negedge monitor watches the
// SPI pins, plays a 3-wire slave, and checks each transaction at its done pulse.
module tb_zest_spi_arb;

    localparam int N_DEV     = 4;
    localparam int DW        = 24;
    localparam int LW        = 5;
    localparam int CLK_DIV   = 2;
    localparam int ADDR_BITS = 16;
    localparam int CS_GAP    = 2;

    typedef struct {
        int          dev;
        int          n;
        logic [23:0] data;
        bit          rdEff;
        logic [23:0] slv;
    } txn_t;

    logic clk;
    logic rst;

    zest_spi_arb_if #(.N_DEV(N_DEV), .DW(DW), .LW(LW)) bus ();

    zest_spi_arb #(
        .N_DEV(N_DEV), .DW(DW), .LW(LW), .CLK_DIV(CLK_DIV),
        .ADDR_BITS(ADDR_BITS), .CS_GAP(CS_GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          nChecks = 0;
    int          nFail   = 0;
    int          invViol = 0;
    txn_t        expQ[$];
    int          rrModel = 0;

    logic [23:0] pData[N_DEV];
    int          pN[N_DEV];
    bit          pRd[N_DEV];
    logic [23:0] pSlv[N_DEV];

    txn_t        cur;
    bit          active    = 1'b0;
    int          monRises  = 0;
    int          csbLow    = 0;
    int          oeErr     = 0;
    int          sinceDone = 1000;
    logic [31:0] capSdo    = '0;
    logic        prevSclk  = 1'b0;
    logic [3:0]  prevGnt   = '0;
    logic [23:0] rdataModel = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Requesters drop their request once they see their grant.
    always @(negedge clk) begin
        for (int d = 0; d < N_DEV; d++) begin
            if (bus.gnt[d]) bus.req[d] = 1'b0;
        end
    end

    // Pin monitor, 3-wire slave model and scoreboard checker.
    always @(negedge clk) begin
        if (rst) begin
            expQ.delete();
            active     = 1'b0;
            rdataModel = '0;
            sinceDone  = 1000;
            prevSclk   = 1'b0;
            prevGnt    = '0;
            monRises   = 0;
            bus.sdi    = 1'b0;
        end else begin
            sinceDone++;
            if ($countones(~bus.csb) > 1) invViol++;
            if ($countones(bus.gnt) > 1) invViol++;
            if (bus.sclk && (bus.csb == 4'hF)) invViol++;
            if ((bus.csb != 4'hF) && ((~bus.csb & ~bus.gnt) != 4'h0)) invViol++;

            if ((bus.gnt != 4'h0) && (prevGnt == 4'h0)) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected grant", {28'h0, bus.gnt}, 32'h0);
                end else begin
                    cur = expQ[0];
                    checkOutput("grant order", {28'h0, bus.gnt}, 32'h1 << cur.dev);
                    checkOutput("gap before grant", (sinceDone >= CS_GAP + 1) ? 32'd1 : 32'd0, 32'd1);
                    checkOutput("busy at grant", {31'h0, bus.busy}, 32'd1);
                    checkOutput("csb at grant", {28'h0, bus.csb},
                                (cur.n > 0) ? {28'h0, ~(4'b1 << cur.dev)} : 32'hF);
                    active   = 1'b1;
                    monRises = 0;
                    csbLow   = 0;
                    oeErr    = 0;
                    capSdo   = '0;
                end
            end

            if (active && (bus.csb != 4'hF)) csbLow++;

            if (active && bus.sclk && !prevSclk) begin
                monRises++;
                capSdo = {capSdo[30:0], bus.sdo};
                if (bus.sdio_oe !== !(cur.rdEff && (monRises - 1 >= ADDR_BITS))) oeErr++;
            end

            if (bus.done != 4'h0) begin
                if (!active) begin
                    checkOutput("unexpected done", {28'h0, bus.done}, 32'h0);
                end else begin
                    logic [31:0] d32;
                    d32 = {8'h0, cur.data};
                    checkOutput("done one-hot", {28'h0, bus.done}, 32'h1 << cur.dev);
                    checkOutput("csb low cycles", csbLow, (cur.n > 0) ? 2*CLK_DIV*cur.n + CLK_DIV : 0);
                    checkOutput("sclk rises", monRises, cur.n);
                    if (cur.rdEff)
                        checkOutput("sdo addr bits", capSdo >> (cur.n - ADDR_BITS), d32 >> (DW - ADDR_BITS));
                    else
                        checkOutput("sdo data bits", capSdo, d32 >> (DW - cur.n));
                    checkOutput("sdio_oe pattern", oeErr, 0);
                    if (cur.rdEff) rdataModel = cur.slv;
                    checkOutput("rdata", {8'h0, bus.rdata}, {8'h0, rdataModel});
                    checkOutput("gnt clear at done", {28'h0, bus.gnt}, 32'h0);
                    checkOutput("csb idle at done", {28'h0, bus.csb}, 32'hF);
                    void'(expQ.pop_front());
                end
                active    = 1'b0;
                sinceDone = 0;
            end

            if (active && cur.rdEff && (monRises >= ADDR_BITS) && (monRises < cur.n))
                bus.sdi = cur.slv[cur.n - 1 - monRises];
            else
                bus.sdi = 1'($urandom_range(0, 1));

            prevSclk = bus.sclk;
            prevGnt  = bus.gnt;
        end
    end

    task automatic setupDev(input int d, input logic [23:0] data, input int n, input bit rdIn, input logic [23:0] slv);
        pData[d] = data;
        pN[d]    = n;
        pRd[d]   = rdIn;
        pSlv[d]  = slv;
    endtask

    task automatic randomDev(input int d);
        int n;
        case ($urandom_range(0, 7))
            0: n = 0;
            1: n = 1;
            2: n = 16;
            3: n = 17;
            4: n = 24;
            5: n = 31;
            default: n = $urandom_range(1, 31);
        endcase
        setupDev(d, 24'($urandom), n, 1'($urandom_range(0, 1)), 24'($urandom));
    endtask

    // Predict the round-robin service order for the set, queue expectations, then raise the requests.
    task automatic applyStimulus(input logic [3:0] mask);
        int last;
        last = -1;
        for (int k = 0; k < N_DEV; k++) begin
            int   d;
            int   nEff;
            txn_t t;
            d = (rrModel + k) % N_DEV;
            if (mask[d]) begin
                nEff    = (pN[d] > DW) ? DW : pN[d];
                t.dev   = d;
                t.n     = nEff;
                t.data  = pData[d];
                t.rdEff = pRd[d] && (nEff > ADDR_BITS);
                t.slv   = t.rdEff ? (pSlv[d] & ((24'd1 << (nEff - ADDR_BITS)) - 24'd1)) : 24'd0;
                expQ.push_back(t);
                last = d;
            end
        end
        if (last >= 0) rrModel = (last + 1) % N_DEV;
        @(posedge clk); #1;
        for (int d = 0; d < N_DEV; d++) begin
            if (mask[d]) begin
                bus.wr_data[d*DW +: DW] = pData[d];
                bus.nbits[d*LW +: LW]   = LW'(pN[d]);
                bus.rd[d]               = pRd[d];
                bus.req[d]              = 1'b1;
            end
        end
    endtask

    task automatic waitIdle(input string tag);
        int budget;
        budget = 3000;
        @(negedge clk);
        while ((expQ.size() != 0 || bus.busy || bus.req != 4'h0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL %s: idle wait timed out with %0d transactions pending", tag, expQ.size());
        end
    endtask

    initial begin
        int budget;
        rst         = 1'b1;
        bus.req     = '0;
        bus.wr_data = '0;
        bus.nbits   = '0;
        bus.rd      = '0;
        bus.sdi     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset gnt",     {28'h0, bus.gnt},     32'h0);
        checkOutput("reset done",    {28'h0, bus.done},    32'h0);
        checkOutput("reset csb",     {28'h0, bus.csb},     32'hF);
        checkOutput("reset sclk",    {31'h0, bus.sclk},    32'h0);
        checkOutput("reset sdo",     {31'h0, bus.sdo},     32'h0);
        checkOutput("reset sdio_oe", {31'h0, bus.sdio_oe}, 32'h0);
        checkOutput("reset busy",    {31'h0, bus.busy},    32'h0);
        checkOutput("reset rdata",   {8'h0, bus.rdata},    32'h0);
        rst = 1'b0;

        setupDev(1, 24'hA5C3F0, 24, 1'b0, 24'h0);
        applyStimulus(4'b0010);
        waitIdle("dev1 write");

        setupDev(2, 24'h801400, 24, 1'b1, 24'h00005A);
        applyStimulus(4'b0100);
        waitIdle("dev2 read");
        checkOutput("dev2 read rdata", {8'h0, bus.rdata}, 32'h0000005A);

        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < N_DEV; d++) randomDev(d);
            applyStimulus(4'hF);
            waitIdle("all request");
        end

        setupDev(0, 24'hFFFFFF, 0, 1'b0, 24'h0);
        setupDev(1, 24'h3C5A96, 31, 1'b0, 24'h0);
        applyStimulus(4'b0011);
        waitIdle("length bounds");

        setupDev(3, 24'h6E2B91, 24, 1'b0, 24'h0);
        applyStimulus(4'b1000);
        budget = 1000;
        while (monRises < 11 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput("reached bit 10", (monRises >= 11) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort csb",     {28'h0, bus.csb},     32'hF);
        checkOutput("abort sclk",    {31'h0, bus.sclk},    32'h0);
        checkOutput("abort sdio_oe", {31'h0, bus.sdio_oe}, 32'h0);
        checkOutput("abort gnt",     {28'h0, bus.gnt},     32'h0);
        rst     = 1'b0;
        rrModel = 0;
        budget  = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done != 4'h0) budget++;
        end
        checkOutput("no done after abort", budget, 0);
        applyStimulus(4'b1000);
        waitIdle("dev3 after abort");

        for (int r = 0; r < 30; r++) begin
            for (int d = 0; d < N_DEV; d++) randomDev(d);
            applyStimulus(4'($urandom_range(1, 15)));
            waitIdle("random set");
        end

        checkOutput("invariants", invViol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
